// File: rtl/vga_line_sequencer.sv
// 640x480@60 raster timing with one line-buffer fill request per active line.
// Also produces the per-line audio strobe for the PWM audio generator.
module vga_line_sequencer #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int FETCH_LEAD = 32
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_line_ack,
    output logic [9:0] o_hpos,
    output logic [9:0] o_vpos,
    output logic       o_display_on,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_frame_start,
    output logic       o_audio_tick,
    output logic       o_line_req,
    output logic [9:0] o_line_y,
    output logic       o_underrun
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] FETCH_PRE = 10'(H_TOTAL - FETCH_LEAD - 1);

    typedef enum logic {
        IDLE,
        PEND
    } state_t;

    logic [9:0] r_hpos;
    logic [9:0] r_vpos;
    state_t     r_state;
    logic [9:0] r_line_y;
    logic       r_underrun;

    logic       w_hwrap;
    logic [9:0] w_next_line;
    logic       w_fetch;
    state_t     w_state_nx;
    logic [9:0] w_line_y_nx;
    logic       w_underrun_nx;

    assign w_hwrap     = (r_hpos == H_LAST);
    assign w_next_line = (r_vpos == V_LAST) ? 10'd0 : r_vpos + 10'd1;
    // Counters enter the fetch point on this edge; hpos does not wrap here,
    // so the line below the current one is the target.
    assign w_fetch     = (r_hpos == FETCH_PRE) && (w_next_line < V_ACT);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hpos <= FETCH_PRE;
            r_vpos <= V_LAST;
        end else if (w_hwrap) begin
            r_hpos <= 10'd0;
            r_vpos <= w_next_line;
        end else begin
            r_hpos <= r_hpos + 10'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_line_y   <= 10'd0;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_line_y   <= w_line_y_nx;
            r_underrun <= w_underrun_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_line_y_nx   = r_line_y;
        w_underrun_nx = r_underrun;
        unique case (r_state)
            IDLE: begin
                if (w_fetch) begin
                    w_state_nx  = PEND;
                    w_line_y_nx = w_next_line;
                end
            end
            PEND: begin
                // An ack on the wrap edge itself still counts as on time.
                if (i_line_ack) begin
                    w_state_nx = IDLE;
                end else if (w_hwrap) begin
                    w_state_nx    = IDLE;
                    w_underrun_nx = 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign o_hpos        = r_hpos;
    assign o_vpos        = r_vpos;
    assign o_display_on  = (r_hpos < H_ACT) && (r_vpos < V_ACT);
    assign o_hsync       = !((r_hpos >= HS_START) && (r_hpos < HS_END));
    assign o_vsync       = !((r_vpos >= VS_START) && (r_vpos < VS_END));
    assign o_frame_start = (r_hpos == 10'd0) && (r_vpos == 10'd0);
    assign o_audio_tick  = (r_hpos == 10'd0);
    assign o_line_req    = (r_state == PEND);
    assign o_line_y      = r_line_y;
    assign o_underrun    = r_underrun;

endmodule
